timer_mc: RTL
=============

Name: timer_mc

Overview:
- Multi-channel, parametrised successor of the single-channel prescaled up-timer.
- NCH independent channels. Each channel has its own prescaler, reload value, enable, go, auto-load and interrupt.
- Sits on the PicoBlaze port bus: address/ren strobes acknowledge interrupts. go is held in an external register that the block clears through go_clear. A combined irq output feeds the processor interrupt line.

Parameters:
- NCH, 2, number of timer channels (1..8).
- WIDTH, 16, counter width per channel.
- PS_W, 3, prescaler select width; divide ratio is 2^conf, max 2^(2^PS_W-1).
- ADDR, 8'h00, base port address; channel i is acknowledged at ADDR+i.

Ports:
- clk_in  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- prescaler_conf  in  NCH*PS_W  per-channel prescaler select, channel i at [i*PS_W +: PS_W].
- timer_conf  in  NCH*WIDTH  per-channel load/reload value.
- en  in  NCH  per-channel enable (H).
- go  in  NCH  per-channel start request (H), level, held externally.
- auto_load  in  NCH  per-channel auto-restart after rollover (H).
- address  in  8  port address.
- ren  in  1  read strobe; ren with address==ADDR+i clears tmr_int[i].
- go_clear  out  NCH  one-cycle pulse: go for channel i accepted.
- tmr_int  out  NCH  per-channel interrupt flag, sticky.
- irq  out  1  registered OR of tmr_int.

Behaviour:
- Reset: all outputs 0, all channels IDLE, counters 0, prescalers 0. Reset mid-run aborts the channel immediately, with no interrupt.
- Channel FSM has two states, IDLE and RUN.
- IDLE -> RUN: en[i]=1 and go[i]=1 sampled at edge k.
  - At edge k: cnt <= timer_conf slice, ps_cnt <= 0.
  - go_clear[i]=1 during cycle k+1 only.
- RUN, en[i]=0: -> IDLE at next edge; cnt held; tmr_int untouched.
- Tick: in RUN, tick when ps_cnt == 2^conf-1, then ps_cnt <= 0; otherwise ps_cnt++. conf=0 gives a tick every cycle. prescaler_conf is sampled live; a change mid-run takes effect on the next compare.
- On tick:
  - If cnt != all-ones: cnt <= cnt+1.
  - If cnt == all-ones (rollover): tmr_int[i] <= 1.
    - auto_load=1: cnt <= timer_conf, stay in RUN.
    - auto_load=0: -> IDLE.
- Interval: (2^WIDTH - timer_conf) ticks from go acceptance to the tmr_int rise. timer_conf=all-ones gives 1 tick.
- go still high in IDLE after a one-shot completes: restarts, since go is a level. Software/go_clear path owns clearing.
- Interrupt clear: ren=1 and address==ADDR+i clears tmr_int[i] at that edge. A rollover on the same edge wins (flag stays 1). Addresses outside ADDR..ADDR+NCH-1 have no effect.
- irq = registered OR of tmr_int, one cycle behind tmr_int.
- Counter arithmetic: unsigned, modulo 2^WIDTH. Channels never interact.

Optional Feature:
- Macro TIMER_READBACK_EN.
- Defined: adds output rdata [WIDTH-1:0]. On ren with address==ADDR+i, rdata <= cnt of channel i at that edge, valid from the next cycle and held until the next matching read. rdata resets to 0. The interrupt clear still occurs on the same access.
- Undefined: no rdata port, no capture register.

Decomposition:
- Package timer_pkg holds:
  - the state encoding (ST_IDLE, ST_RUN);
  - a prescaler-count width function/constant derived from PS_W;
  - a default ADDR constant.
- Sub-module timer_channel holds one FSM + prescaler + counter + tmr_int. Its inputs are a per-channel ack strobe and the config slices. The top uses a generate loop for NCH instances, plus address decode, irq OR and the optional readback mux.

Test Plan:
- NCH=2, WIDTH=16. Ch0: conf=0, timer_conf=16'hFFF0, en=1, go pulse at edge k -> go_clear[0] high in cycle k+1; tmr_int[0] rises at edge k+16; channel IDLE afterwards; irq one cycle later.
- Ch0: conf=2 (divide 4), timer_conf=16'hFFFE -> tmr_int rises 8 clocks after go acceptance.
- auto_load=1, timer_conf=16'hFFF0, conf=0 -> tmr_int sets every 16 clocks. ren with address=ADDR clears it. A clear on the same edge as a rollover leaves it 1.
- Both channels running, different reloads. ren at ADDR+1 clears only tmr_int[1]; ren at ADDR+2 clears nothing.
- rst asserted mid-count -> all outputs 0 next cycle, no interrupt. en dropped mid-run -> IDLE, count frozen, no tmr_int.
- With TIMER_READBACK_EN: ren at ADDR while ch0 is 5 ticks past load 16'hFFF0 -> rdata=16'hFFF5 next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: the channel state encoding,
// the prescaler counter sizing and the default port base address.
package timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  localparam logic [7:0] ADDR_DEFAULT = 8'h00;

  // The largest divide is 2^(2^ps_w-1), so the prescaler needs 2^ps_w-1 bits.
  function automatic int ps_cnt_w(input int ps_w);
    return (ps_w < 1) ? 1 : ((1 << ps_w) - 1);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM, 2^conf prescaler, up-counter and sticky interrupt.
// state   | meaning
// ST_IDLE | waiting for en & go; counter holds its last value
// ST_RUN  | prescaled ticks advance the counter toward rollover
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PS_W  = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [PS_W-1:0]  prescaler_conf,
  input  logic [WIDTH-1:0] timer_conf,
  input  logic             en,
  input  logic             go,
  input  logic             auto_load,
  input  logic             ack,
  output logic             go_clear,
  output logic             tmr_int
`ifdef TIMER_READBACK_EN
  ,
  output logic [WIDTH-1:0] count
`endif
);

  localparam int PSC_W = ps_cnt_w(PS_W);

  ch_state_e        state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [PSC_W-1:0] ps_cnt, ps_nxt, ps_max;
  logic             go_clear_nxt, int_nxt, tick, rollover;

  // The shift wraps to zero at the widest divide, so the subtraction yields all-ones.
  assign ps_max   = (PSC_W'(1) << prescaler_conf) - PSC_W'(1);
  assign tick     = (state == ST_RUN) && en && (ps_cnt == ps_max);
  assign rollover = tick && (cnt == '1);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ps_nxt       = ps_cnt;
    go_clear_nxt = 1'b0;
    int_nxt      = rollover ? 1'b1 : (ack ? 1'b0 : tmr_int);
    case (state)
      ST_IDLE: begin
        if (en && go) begin
          state_nxt    = ST_RUN;
          cnt_nxt      = timer_conf;
          ps_nxt       = '0;
          go_clear_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          ps_nxt = '0;
          if (rollover) begin
            if (auto_load) cnt_nxt = timer_conf;
            else           state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          ps_nxt = ps_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ps_cnt   <= '0;
      go_clear <= 1'b0;
      tmr_int  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ps_cnt   <= ps_nxt;
      go_clear <= go_clear_nxt;
      tmr_int  <= int_nxt;
    end
  end

`ifdef TIMER_READBACK_EN
  assign count = cnt;
`endif

endmodule

// File: rtl/timer_mc.sv
// Multi-channel prescaled up-timer on the PicoBlaze port bus.
// Define TIMER_READBACK_EN to add the rdata counter-capture port.
module timer_mc
  import timer_pkg::*;
#(
  parameter int         NCH   = 2,
  parameter int         WIDTH = 16,
  parameter int         PS_W  = 3,
  parameter logic [7:0] ADDR  = ADDR_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [NCH*PS_W-1:0]   prescaler_conf,
  input  logic [NCH*WIDTH-1:0]  timer_conf,
  input  logic [NCH-1:0]        en,
  input  logic [NCH-1:0]        go,
  input  logic [NCH-1:0]        auto_load,
  input  logic [7:0]            address,
  input  logic                  ren,
  output logic [NCH-1:0]        go_clear,
  output logic [NCH-1:0]        tmr_int,
  output logic                  irq
`ifdef TIMER_READBACK_EN
  ,
  output logic [WIDTH-1:0]      rdata
`endif
);

  logic [NCH-1:0] ack;
`ifdef TIMER_READBACK_EN
  logic [WIDTH-1:0] cnt_arr [NCH];
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ack[i] = ren && (address == 8'(ADDR + i));

    timer_channel #(
      .WIDTH (WIDTH),
      .PS_W  (PS_W)
    ) u_ch (
      .clk_in         (clk_in),
      .rst            (rst),
      .prescaler_conf (prescaler_conf[i*PS_W +: PS_W]),
      .timer_conf     (timer_conf[i*WIDTH +: WIDTH]),
      .en             (en[i]),
      .go             (go[i]),
      .auto_load      (auto_load[i]),
      .ack            (ack[i]),
      .go_clear       (go_clear[i]),
      .tmr_int        (tmr_int[i])
`ifdef TIMER_READBACK_EN
      ,
      .count          (cnt_arr[i])
`endif
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst) irq <= 1'b0;
    else     irq <= |tmr_int;
  end

`ifdef TIMER_READBACK_EN
  // At most one channel matches the address, so the last-match loop is a plain mux.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ack[i]) rdata <= cnt_arr[i];
      end
    end
  end
`endif

endmodule
